// File: rtl/alu_issuer_pkg.sv
// Shared definitions for the ALU instruction issuer.
// Covers instruction field positions, opcode values and FSM state encodings.
package alu_issuer_pkg;

    localparam int INSTR_W  = 12;
    localparam int HALT_BIT = 11;
    localparam int SEL_MSB  = 10;
    localparam int SEL_LSB  = 8;
    localparam int RS_MSB   = 7;
    localparam int RS_LSB   = 4;
    localparam int RT_MSB   = 3;
    localparam int RT_LSB   = 0;

    localparam logic [2:0] OP_SUB  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_SRA  = 3'b100;
    localparam logic [2:0] OP_ROTL = 3'b101;
    localparam logic [2:0] OP_LT   = 3'b110;
    localparam logic [2:0] OP_EQ   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_prog_mem.sv
// Program store: DEPTH x INSTR_W registers with async clear, synchronous write
// and two combinational read ports (current entry and the one to issue next).
module alu_prog_mem
    import alu_issuer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [AW-1:0]      raddr_a,
    output logic [INSTR_W-1:0] rdata_a,
    input  logic [AW-1:0]      raddr_b,
    output logic [INSTR_W-1:0] rdata_b
);

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_instr_issuer.sv
// Steps a loadable program through the 4-bit ALU datapath and captures each result.
// Optional single-step mode (HOLD state, step port) is enabled by ALU_ISSUER_STEP_EN.
module alu_instr_issuer
    import alu_issuer_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int SETTLE = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [11:0]   load_instr,
    input  logic          start,
`ifdef ALU_ISSUER_STEP_EN
    input  logic          step,
`endif
    output logic [3:0]    rs,
    output logic [3:0]    rt,
    output logic [2:0]    sel,
    input  logic [3:0]    rd,
    output logic          res_valid,
    output logic [3:0]    res_data,
    output logic [AW-1:0] res_idx,
    output logic          busy,
    output logic          done
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t             state;
    state_t             state_nx;
    logic [AW-1:0]      pc;
    logic [CW-1:0]      cnt;
    logic [AW-1:0]      nxt_addr;
    logic [INSTR_W-1:0] cur_instr;
    logic [INSTR_W-1:0] nxt_instr;
    logic               last_entry;
    logic               mem_we;
    logic               launch;
    logic               capture;
`ifdef ALU_ISSUER_STEP_EN
    logic               resume;
`endif

    // Port b fetches entry 0 while idle (for start) and entry pc+1 while running.
    assign nxt_addr = (state == ST_IDLE) ? '0 : pc + AW'(1);

    alu_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we      (mem_we),
        .waddr   (load_addr),
        .wdata   (load_instr),
        .raddr_a (pc),
        .rdata_a (cur_instr),
        .raddr_b (nxt_addr),
        .rdata_b (nxt_instr)
    );

    assign last_entry = cur_instr[HALT_BIT] || (pc == AW'(DEPTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (start && !load_en) begin
                    state_nx = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt == CW'(SETTLE - 1)) begin
                    if (last_entry) begin
                        state_nx = ST_IDLE;
                    end else begin
`ifdef ALU_ISSUER_STEP_EN
                        state_nx = ST_HOLD;
`else
                        state_nx = ST_SETTLE;
`endif
                    end
                end
            end
`ifdef ALU_ISSUER_STEP_EN
            ST_HOLD: begin
                if (step) begin
                    state_nx = ST_SETTLE;
                end
            end
`endif
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_we  = 1'b0;
        launch  = 1'b0;
        capture = 1'b0;
`ifdef ALU_ISSUER_STEP_EN
        resume  = 1'b0;
`endif
        busy    = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                mem_we = load_en;
                launch = start && !load_en;
            end
            ST_SETTLE: begin
                capture = (cnt == CW'(SETTLE - 1));
            end
`ifdef ALU_ISSUER_STEP_EN
            ST_HOLD: begin
                resume = step;
            end
`endif
            default: ;
        endcase
    end

    // The next instruction is issued on the same edge that captures the current result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= '0;
            cnt       <= '0;
            rs        <= '0;
            rt        <= '0;
            sel       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_idx   <= '0;
            done      <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            done      <= 1'b0;
            if (launch) begin
                pc  <= '0;
                cnt <= '0;
                rs  <= nxt_instr[RS_MSB:RS_LSB];
                rt  <= nxt_instr[RT_MSB:RT_LSB];
                sel <= nxt_instr[SEL_MSB:SEL_LSB];
            end else if (capture) begin
                res_data  <= rd;
                res_idx   <= pc;
                res_valid <= 1'b1;
                if (last_entry) begin
                    done <= 1'b1;
                end else begin
                    pc  <= pc + AW'(1);
                    cnt <= '0;
                    rs  <= nxt_instr[RS_MSB:RS_LSB];
                    rt  <= nxt_instr[RT_MSB:RT_LSB];
                    sel <= nxt_instr[SEL_MSB:SEL_LSB];
                end
            end else if (state == ST_SETTLE) begin
                cnt <= cnt + CW'(1);
`ifdef ALU_ISSUER_STEP_EN
            end else if (resume) begin
                cnt <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_instr_issuer.sv
// Scoreboard bench for alu_instr_issuer: a reference ALU drives rd, a program model
// predicts every result, and a negedge monitor checks each res_valid pulse.
module tb_alu_instr_issuer;
    import alu_issuer_pkg::*;

    localparam int DEPTH  = 8;
    localparam int AW     = 3;
    localparam int SETTLE = 2;

    typedef struct {
        logic [3:0]    data;
        logic [AW-1:0] idx;
        logic          done;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [11:0]   load_instr = '0;
    logic          start = 1'b0;
`ifdef ALU_ISSUER_STEP_EN
    logic          step = 1'b0;
`endif
    logic [3:0]    rs, rt, rd, res_data;
    logic [2:0]    sel;
    logic          res_valid, busy, done;
    logic [AW-1:0] res_idx;

    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    logic [11:0]   prog [DEPTH];
    exp_t          exp_q [$];

    // Behavioural datapath: the issuer only forwards whatever this produces.
    function automatic logic [3:0] alu_ref(input logic [2:0] op, input logic [3:0] a,
                                           input logic [3:0] b);
        int x;
        int y;
        int r;
        x = int'(a);
        y = int'(b);
        case (op)
            OP_SUB:  r = x - y;
            OP_ADD:  r = x + y;
            OP_OR:   r = x | y;
            OP_AND:  r = x & y;
            OP_SRA:  r = (y >> 1) | (y & 8);
            OP_ROTL: r = (x << 1) | (x >> 3);
            OP_LT:   r = (x < y) ? 11 : 10;
            OP_EQ:   r = (x == y) ? 15 : 0;
            default: r = 0;
        endcase
        return 4'(r & 15);
    endfunction

    assign rd = alu_ref(sel, rs, rt);

    alu_instr_issuer #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .SETTLE (SETTLE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_instr (load_instr),
        .start      (start),
`ifdef ALU_ISSUER_STEP_EN
        .step       (step),
`endif
        .rs         (rs),
        .rt         (rt),
        .sel        (sel),
        .rd         (rd),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_idx    (res_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic applyStimulus(input int addr, input logic [11:0] instr);
        load_en    = 1'b1;
        load_addr  = AW'(addr);
        load_instr = instr;
        @(negedge clk);
        load_en    = 1'b0;
        prog[addr] = instr;
    endtask

    // Pulses start and queues the predicted results; optionally pokes start/load while busy.
    task automatic start_run(input bit inject);
        exp_t e;
        int   launch;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        launch = cyc;
        for (int k = 0; k < DEPTH; k++) begin
            e.data = alu_ref(prog[k][10:8], prog[k][7:4], prog[k][3:0]);
            e.idx  = AW'(k);
            e.done = prog[k][11] || (k == DEPTH - 1);
`ifdef ALU_ISSUER_STEP_EN
            e.cyc  = -1;
`else
            e.cyc  = launch + SETTLE * (k + 1);
`endif
            exp_q.push_back(e);
            if (e.done) break;
        end
        checkOutput("busy_after_start", busy, 1);
        if (inject) begin
            load_en    = 1'b1;
            load_addr  = AW'(1);
            load_instr = ~prog[1];
            start      = 1'b1;
            @(negedge clk);
            load_en = 1'b0;
            start   = 1'b0;
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 400) begin
`ifdef ALU_ISSUER_STEP_EN
            if (res_valid) step = 1'b1;
`endif
            @(negedge clk);
`ifdef ALU_ISSUER_STEP_EN
            step = 1'b0;
`endif
            t++;
        end
        checkOutput("run_completes", done, 1);
        @(negedge clk);
        checkOutput("idle_after_done", busy, 0);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic run_program(input bit inject);
        start_run(inject);
        wait_done();
    endtask

    task automatic wait_first_result();
        int t = 0;
        while (!res_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        checkOutput("first_result_seen", res_valid, 1);
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_rs"}, rs, 0);
        checkOutput({tag, "_rt"}, rt, 0);
        checkOutput({tag, "_sel"}, sel, 0);
        checkOutput({tag, "_res_valid"}, res_valid, 0);
        checkOutput({tag, "_res_data"}, res_data, 0);
        checkOutput({tag, "_res_idx"}, res_idx, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && res_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_res_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("res_data", res_data, e.data);
                checkOutput("res_idx", res_idx, e.idx);
                checkOutput("done_with_result", done, e.done);
                if (e.cyc >= 0) checkOutput("result_cycle", cyc, e.cyc);
            end
        end else if (!rst && done) begin
            checkOutput("done_without_result", 1, 0);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) prog[i] = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single add");
        applyStimulus(0, {1'b1, OP_ADD, 4'h3, 4'h4});
        run_program(1'b0);

        $display("[TB] sub wrap, rotl, sra");
        applyStimulus(0, {1'b1, OP_SUB, 4'h2, 4'h5});
        run_program(1'b0);
        applyStimulus(0, {1'b1, OP_ROTL, 4'h9, 4'h0});
        run_program(1'b0);
        applyStimulus(0, {1'b1, OP_SRA, 4'h0, 4'h8});
        run_program(1'b0);

        $display("[TB] compare sequence");
        applyStimulus(0, {1'b0, OP_LT, 4'h2, 4'h5});
        applyStimulus(1, {1'b0, OP_LT, 4'h5, 4'h2});
        applyStimulus(2, {1'b1, OP_EQ, 4'h5, 4'h5});
        run_program(1'b0);

        $display("[TB] full program without halt");
        for (int i = 0; i < DEPTH; i++) applyStimulus(i, {1'b0, OP_ADD, 4'h1, 4'h1});
        run_program(1'b0);

        $display("[TB] load priority and busy lockout");
        load_en    = 1'b1;
        start      = 1'b1;
        load_addr  = '0;
        load_instr = {1'b1, OP_OR, 4'hA, 4'h5};
        @(negedge clk);
        load_en = 1'b0;
        start   = 1'b0;
        prog[0] = {1'b1, OP_OR, 4'hA, 4'h5};
        checkOutput("start_with_load_ignored", busy, 0);
        @(negedge clk);
        checkOutput("still_idle", busy, 0);
        run_program(1'b0);
        applyStimulus(0, {1'b0, OP_AND, 4'hC, 4'hA});
        applyStimulus(1, {1'b0, OP_SUB, 4'h1, 4'h7});
        applyStimulus(2, {1'b1, OP_ADD, 4'hF, 4'h2});
        run_program(1'b1);
        run_program(1'b0);

`ifdef ALU_ISSUER_STEP_EN
        $display("[TB] hold until step");
        start_run(1'b0);
        wait_first_result();
        repeat (6) begin
            @(negedge clk);
            checkOutput("held_busy", busy, 1);
        end
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        wait_done();
`endif

        $display("[TB] reset mid-run");
        start_run(1'b0);
        wait_first_result();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) prog[i] = '0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("no_done_in_reset", done, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        run_program(1'b0);

        $display("[TB] random programs");
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                logic [11:0] ins;
                ins     = 12'($urandom);
                ins[11] = ($urandom_range(0, 3) == 0);
                applyStimulus(i, ins);
            end
            run_program(r[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
